// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
//   Sequential AES key expansion for AES-128/192/256. A start pulse loads the
//   cipher key into the round-key store. One new 32-bit word is then derived
//   per clock until all 4*(Nr+1) words exist. Any round key can then be read
//   through a registered port, in encrypt or decrypt (reversed) order.
//
// Parameters
//   KEY_BITS    cipher key width: 128, 192 or 256
//
// Ports
//   Clk         clock, rising edge
//   Rst         asynchronous active-low reset
//   i_Start     start expansion (accepted in IDLE or DONE)
//   i_Key       cipher key, big-endian bytes, sampled with accepted i_Start
//   i_RdRound   requested round index 0..Nr
//   i_fEncrypt  1 = encrypt order, 0 = decrypt order
//   o_Busy      expansion in progress
//   o_Ready     key store valid
//   o_RoundKey  selected round key, one-cycle registered read
//
// Optional feature macro: INV_MIX_KEY_EN
//   When defined, decrypt reads of the middle rounds return InvMixColumns of
//   the stored key (equivalent inverse cipher keys).
// ---------------------------------------------------------------------------
module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                i_Start,
  input  logic [KEY_BITS-1:0] i_Key,
  input  logic [3:0]          i_RdRound,
  input  logic                i_fEncrypt,
  output logic                o_Busy,
  output logic                o_Ready,
  output logic [127:0]        o_RoundKey
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_W     = 4'(NR);
  localparam logic [2:0] POS_LAST = 3'(NK - 1);
  localparam bit         IS_256   = (NK == 8);

  // Forward S-box, byte 0x00 in the most significant position
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state, next_state;
  logic [31:0] w [NW];
  logic [5:0]  cnt;
  logic [2:0]  pos;
  logic [7:0]  rcon;
  logic        load, step;
  logic [31:0] prev_word, back_word, sub_in, sub_out, t_word, new_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2040 - {x, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

`ifdef INV_MIX_KEY_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // State register and expansion bookkeeping. pos tracks i mod Nk and rcon
  // tracks Rcon[i/Nk], so no divider is needed.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
      pos   <= '0;
      rcon  <= 8'h01;
    end else begin
      state <= next_state;
      if (load) begin
        cnt  <= NK_W;
        pos  <= '0;
        rcon <= 8'h01;
      end else if (step) begin
        cnt <= cnt + 6'd1;
        pos <= (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
        if (pos == 3'd0) rcon <= xtime(rcon);
      end
    end
  end

  // Next-state logic: a start in EXPAND is deliberately ignored
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_Start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (cnt == LAST_W) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Word recurrence. One 4-byte SubWord serves both the RotWord case and the
  // extra AES-256 substitution.
  always_comb begin
    prev_word = w[cnt - 6'd1];
    back_word = w[cnt - NK_W];
    sub_in    = (pos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    if (pos == 3'd0)
      t_word = sub_out ^ {rcon, 24'h0};
    else if (IS_256 && pos == 3'd4)
      t_word = sub_out;
    else
      t_word = prev_word;
    new_word = back_word ^ t_word;
  end

  // Round-key store; contents survive reset and are rebuilt on each start
  always_ff @(posedge Clk) begin
    if (load) begin
      for (int k = 0; k < NK; k++) w[k] <= i_Key[KEY_BITS-1-32*k -: 32];
    end else if (step) begin
      w[cnt] <= new_word;
    end
  end

  assign o_Busy  = (state == EXPAND);
  assign o_Ready = (state == DONE);

  logic [3:0]   r_raw, r_sel;
  logic         in_range, rd_ok;
  logic [5:0]   base;
  logic [127:0] stored_key, rk_next;

  // Read selection. Out-of-range requests are steered to round 0 so the store
  // is never indexed past its end; the result is zeroed anyway.
  always_comb begin
    r_raw      = i_fEncrypt ? i_RdRound : NR_W - i_RdRound;
    in_range   = (i_RdRound <= NR_W);
    rd_ok      = o_Ready && in_range;
    r_sel      = in_range ? r_raw : 4'd0;
    base       = {r_sel, 2'b00};
    stored_key = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
`ifdef INV_MIX_KEY_EN
    if (!i_fEncrypt && r_sel != 4'd0 && r_sel != NR_W)
      rk_next = {inv_mix_col(stored_key[127:96]), inv_mix_col(stored_key[95:64]),
                 inv_mix_col(stored_key[63:32]),  inv_mix_col(stored_key[31:0])};
    else
      rk_next = stored_key;
`else
    rk_next = stored_key;
`endif
  end

  // Registered read port, updated every cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      o_RoundKey <= '0;
    else
      o_RoundKey <= rd_ok ? rk_next : 128'h0;
  end

endmodule
